// File: rtl/user_btn_debounce.sv
// rtl/user_btn_debounce.sv - push-button synchronizer and debounce FSM with press/release/long-press strobes
module user_btn_debounce #(
    parameter int DEBOUNCE_CYCLES   = 156500,
    parameter int LONG_PRESS_CYCLES = 15650000,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst,
    input  logic       i_user_btn0,
    output logic       o_btn_level,
    output logic       o_press,
    output logic       o_release,
    output logic       o_long_press,
    output logic [7:0] o_press_count
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_PRESS_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic PIN_RELEASED = ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_PEND = 2'd1,
        PRESSED    = 2'd2,
        REL_PEND   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_s1;
    logic          r_s2;
    logic          w_s2n;
    logic [DW-1:0] r_deb_cnt;
    logic [DW-1:0] w_deb_cnt_nxt;
    logic [HW-1:0] r_hold_cnt;
    logic [HW-1:0] w_hold_cnt_nxt;
    logic          r_long_done;
    logic          w_long_done_nxt;
    logic          r_btn_level;
    logic          r_press;
    logic          r_release;
    logic          r_long_press;
    logic [7:0]    r_press_count;
    logic          w_level_nxt;
    logic          w_press_nxt;
    logic          w_release_nxt;
    logic          w_long_nxt;
    logic [7:0]    w_count_nxt;
    logic          w_commit_press;
    logic          w_commit_release;
    logic          w_holding;

    // Normalize so that 1 always means pressed regardless of pin polarity.
    assign w_s2n            = r_s2 ^ PIN_RELEASED;
    assign w_commit_press   = (r_state == PRESS_PEND) && w_s2n && (r_deb_cnt == DEB_LAST);
    assign w_commit_release = (r_state == REL_PEND) && !w_s2n && (r_deb_cnt == DEB_LAST);
    assign w_holding        = (r_state == PRESSED) || (r_state == REL_PEND);

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_s1          <= PIN_RELEASED;
            r_s2          <= PIN_RELEASED;
            r_state       <= IDLE;
            r_deb_cnt     <= '0;
            r_hold_cnt    <= '0;
            r_long_done   <= 1'b0;
            r_btn_level   <= 1'b0;
            r_press       <= 1'b0;
            r_release     <= 1'b0;
            r_long_press  <= 1'b0;
            r_press_count <= 8'd0;
        end else begin
            r_s1          <= i_user_btn0;
            r_s2          <= r_s1;
            r_state       <= w_state_nxt;
            r_deb_cnt     <= w_deb_cnt_nxt;
            r_hold_cnt    <= w_hold_cnt_nxt;
            r_long_done   <= w_long_done_nxt;
            r_btn_level   <= w_level_nxt;
            r_press       <= w_press_nxt;
            r_release     <= w_release_nxt;
            r_long_press  <= w_long_nxt;
            r_press_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_s2n) w_state_nxt = PRESS_PEND;
            end
            PRESS_PEND: begin
                if (!w_s2n)                     w_state_nxt = IDLE;
                else if (r_deb_cnt == DEB_LAST) w_state_nxt = PRESSED;
            end
            PRESSED: begin
                if (!w_s2n) w_state_nxt = REL_PEND;
            end
            REL_PEND: begin
                if (w_s2n)                      w_state_nxt = PRESSED;
                else if (r_deb_cnt == DEB_LAST) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_deb_cnt_nxt   = r_deb_cnt;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_long_done_nxt = r_long_done;
        w_level_nxt     = r_btn_level;
        w_press_nxt     = w_commit_press;
        w_release_nxt   = w_commit_release;
        w_long_nxt      = 1'b0;
        w_count_nxt     = r_press_count;

        if ((r_state == IDLE && w_s2n) || (r_state == PRESSED && !w_s2n)) begin
            w_deb_cnt_nxt = '0;
        end else if (((r_state == PRESS_PEND && w_s2n) || (r_state == REL_PEND && !w_s2n))
                     && r_deb_cnt != DEB_LAST) begin
            w_deb_cnt_nxt = r_deb_cnt + DW'(1);
        end

        if (w_commit_press) begin
            w_level_nxt     = 1'b1;
            w_count_nxt     = r_press_count + 8'd1;
            w_hold_cnt_nxt  = '0;
            w_long_done_nxt = 1'b0;
        end else if (w_holding) begin
            if (r_hold_cnt != HOLD_LAST) w_hold_cnt_nxt = r_hold_cnt + HW'(1);
            // A release committing in the same cycle wins over the long-press strobe.
            if (r_hold_cnt == HOLD_LAST && !r_long_done) begin
                w_long_done_nxt = 1'b1;
                w_long_nxt      = !w_commit_release;
            end
        end

        if (w_commit_release) w_level_nxt = 1'b0;
    end

    assign o_btn_level   = r_btn_level;
    assign o_press       = r_press;
    assign o_release     = r_release;
    assign o_long_press  = r_long_press;
    assign o_press_count = r_press_count;
endmodule

// File: tb/tb_user_btn_debounce.sv
// tb/tb_user_btn_debounce.sv - randomized and directed check of user_btn_debounce against a run-length model
module tb_user_btn_debounce;
    localparam int D = 4;
    localparam int L = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pin = 1'b1;
    logic       btn_level;
    logic       press;
    logic       rel;
    logic       long_press;
    logic [7:0] press_count;

    int n_vectors = 0;
    int n_miscompares = 0;

    // Model: pin pipeline, committed level, run length of disagreement, age since press.
    logic m_q1, m_q2;
    int   m_level, m_run, m_age, m_fired, m_press, m_rel, m_long, m_count;

    // Observation counters since the last mark().
    int g_step, g_press_at, g_rel_at, g_long_at, g_n_press, g_n_rel, g_n_long;

    user_btn_debounce #(
        .DEBOUNCE_CYCLES(D),
        .LONG_PRESS_CYCLES(L),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .i_sys_clk(clk),
        .i_sys_rst(rst),
        .i_user_btn0(pin),
        .o_btn_level(btn_level),
        .o_press(press),
        .o_release(rel),
        .o_long_press(long_press),
        .o_press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vectors++;
        if (got != exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic mark();
        g_step = 0; g_press_at = 0; g_rel_at = 0; g_long_at = 0;
        g_n_press = 0; g_n_rel = 0; g_n_long = 0;
    endtask

    task automatic model_edge(input logic p, input logic r);
        int s2n;
        int commit;
        if (r) begin
            m_q1 = 1'b1; m_q2 = 1'b1;
            m_level = 0; m_run = 0; m_age = 0; m_fired = 1;
            m_press = 0; m_rel = 0; m_long = 0; m_count = 0;
        end else begin
            s2n = (m_q2 == 1'b0) ? 1 : 0;
            m_q2 = m_q1;
            m_q1 = p;
            m_press = 0; m_rel = 0; m_long = 0;
            commit = 0;
            if (s2n != m_level) begin
                m_run++;
                if (m_run == D + 1) begin
                    commit = 1;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            if (m_level == 1) begin
                m_age++;
                if (m_age == L && m_fired == 0) begin
                    m_fired = 1;
                    if (commit == 0) m_long = 1;
                end
            end
            if (commit == 1) begin
                m_level = 1 - m_level;
                if (m_level == 1) begin
                    m_press = 1;
                    m_count = (m_count + 1) % 256;
                    m_age = 0;
                    m_fired = 0;
                end else begin
                    m_rel = 1;
                end
            end
        end
    endtask

    task automatic step(input logic p, input logic r);
        pin = p;
        rst = r;
        @(posedge clk);
        model_edge(p, r);
        #1;
        check_eq("btn_level", int'(btn_level), m_level);
        check_eq("press", int'(press), m_press);
        check_eq("release", int'(rel), m_rel);
        check_eq("long_press", int'(long_press), m_long);
        check_eq("press_count", int'(press_count), m_count);
        g_step++;
        if (press === 1'b1) begin g_n_press++; if (g_press_at == 0) g_press_at = g_step; end
        if (rel === 1'b1) begin g_n_rel++; if (g_rel_at == 0) g_rel_at = g_step; end
        if (long_press === 1'b1) begin g_n_long++; if (g_long_at == 0) g_long_at = g_step; end
    endtask

    task automatic hold(input logic p, input int n);
        for (int i = 0; i < n; i++) step(p, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        mark();
    endtask

    initial begin
        mark();
        do_reset();
        check_eq("reset_level", int'(btn_level), 0);
        check_eq("reset_count", int'(press_count), 0);

        // Clean press then release.
        hold(1'b0, 10);
        check_eq("clean_press_lat", g_press_at, 7);
        check_eq("clean_press_n", g_n_press, 1);
        check_eq("clean_count", int'(press_count), 1);
        mark();
        hold(1'b1, 10);
        check_eq("clean_rel_lat", g_rel_at, 7);

        // Bounce rejection.
        do_reset();
        hold(1'b1, 3);
        hold(1'b0, 3); hold(1'b1, 1); hold(1'b0, 2); hold(1'b1, 12);
        check_eq("bounce_press_n", g_n_press, 0);
        check_eq("bounce_rel_n", g_n_rel, 0);
        check_eq("bounce_count", int'(press_count), 0);

        // Long press.
        do_reset();
        hold(1'b0, 40);
        check_eq("long_n", g_n_long, 1);
        check_eq("long_lat", g_long_at - g_press_at, L);
        mark();
        hold(1'b1, 12);
        check_eq("long_rel_lat", g_rel_at, 7);
        check_eq("long_level_after", int'(btn_level), 0);
        check_eq("long_n_after", g_n_long, 0);

        // Short press.
        do_reset();
        hold(1'b0, 10);
        check_eq("short_press_n", g_n_press, 1);
        mark();
        hold(1'b1, 30);
        check_eq("short_rel_lat", g_rel_at, 7);
        check_eq("short_long_n", g_n_long, 0);

        // Counter wrap.
        do_reset();
        for (int i = 1; i <= 256; i++) begin
            hold(1'b0, 8);
            check_eq("wrap_count", int'(press_count), i % 256);
            hold(1'b1, 8);
        end

        // Reset while held.
        do_reset();
        hold(1'b0, 10);
        check_eq("mid_level_before", int'(btn_level), 1);
        step(1'b0, 1'b1);
        check_eq("mid_rst_level", int'(btn_level), 0);
        check_eq("mid_rst_strobes", int'(press) + int'(rel) + int'(long_press), 0);
        check_eq("mid_rst_count", int'(press_count), 0);
        mark();
        hold(1'b0, 10);
        check_eq("mid_press_lat", g_press_at, 7);
        check_eq("mid_count", int'(press_count), 1);
        hold(1'b1, 10);

        // Random segments with bounces, long holds and occasional reset.
        for (int seg = 0; seg < 600; seg++) begin
            int len;
            logic lvl;
            lvl = 1'(($urandom & 1));
            case ($urandom_range(0, 9))
                0:       len = $urandom_range(18, 30);
                1, 2:    len = $urandom_range(5, 7);
                default: len = $urandom_range(1, 6);
            endcase
            if ($urandom_range(0, 99) == 0) step(lvl, 1'b1);
            hold(lvl, len);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
